// File: rtl/dsep_pkg.sv
//------------------------------------------------------------------------------
// dsep_pkg : shared constants and state type for the OFDM data separator
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dsep_pkg;
  localparam int DW      = 12;
  localparam int AW      = 10;
  localparam int DEPTH   = 2 ** AW;
  localparam int N_LTS   = 128;
  localparam int N_CP    = 16;
  localparam int N_FFT   = 64;
  localparam int SYM_LEN = N_CP + N_FFT;
  localparam int CW      = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_SYM  = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/dsep_buf.sv
//------------------------------------------------------------------------------
// dsep_buf : simple dual-port sample RAM, one write port, registered read port
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dsep_buf
  import dsep_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [2*DW-1:0] wr_data,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [2*DW-1:0] rd_data
);

  logic [2*DW-1:0] r_mem [DEPTH];
  logic [2*DW-1:0] r_rd_data;

  // Array carries no reset so it can map onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_rd_data <= '0;
    else if (rd_en) r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/dsep.sv
//------------------------------------------------------------------------------
// dsep : splits the buffered sample stream into long preamble and CP-stripped data
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dsep
  import dsep_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] di_re,
  input  logic [DW-1:0] di_im,
  input  logic          di_vld,
  input  logic [AW-1:0] max_indx,
  input  logic          max_indx_vld,
  output logic [DW-1:0] do_preamble_re,
  output logic [DW-1:0] do_preamble_im,
  output logic          do_preamble_vld,
  output logic [DW-1:0] do_sigpld_re,
  output logic [DW-1:0] do_sigpld_im,
  output logic          do_sigpld_vld
);

  state_t            r_state, w_state_nxt;
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_lts_cnt, r_sym_cnt;
  logic              w_consume, w_pre_hit, w_sig_hit;
  logic              r_pre_vld, r_sig_vld;
  logic [2*DW-1:0]   r_pre_hold, r_sig_hold;
  logic [2*DW-1:0]   w_rd_data;

  dsep_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (di_vld),
    .wr_addr (r_wr_ptr),
    .wr_data ({di_re, di_im}),
    .rd_en   (w_consume),
    .rd_addr (r_rd_ptr),
    .rd_data (w_rd_data)
  );

  // A restart pulse suppresses the read of that cycle
  assign w_consume = (r_state != ST_IDLE) && !max_indx_vld && (r_rd_ptr != r_wr_ptr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pre_hit   = 1'b0;
    w_sig_hit   = 1'b0;
    if (max_indx_vld) begin
      w_state_nxt = ST_PRE;
    end else if (w_consume) begin
      case (r_state)
        ST_PRE: begin
          w_pre_hit = 1'b1;
          if (r_lts_cnt == CW'(N_LTS - 1)) w_state_nxt = ST_SYM;
        end
        ST_SYM:  w_sig_hit = (r_sym_cnt >= CW'(N_CP));
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_lts_cnt  <= '0;
      r_sym_cnt  <= '0;
      r_pre_vld  <= 1'b0;
      r_sig_vld  <= 1'b0;
      r_pre_hold <= '0;
      r_sig_hold <= '0;
    end else begin
      if (di_vld) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_pre_vld <= w_pre_hit;
      r_sig_vld <= w_sig_hit;
      if (max_indx_vld) begin
        r_rd_ptr  <= max_indx;
        r_lts_cnt <= '0;
        r_sym_cnt <= '0;
      end else if (w_consume) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        if (r_state == ST_PRE) begin
          r_lts_cnt <= r_lts_cnt + 1'b1;
          r_sym_cnt <= '0;
        end else if (r_state == ST_SYM) begin
          r_sym_cnt <= (r_sym_cnt == CW'(SYM_LEN - 1)) ? '0 : r_sym_cnt + 1'b1;
        end
      end
      // RAM output register is shared, so each port keeps its own copy for hold
      if (r_pre_vld) r_pre_hold <= w_rd_data;
      if (r_sig_vld) r_sig_hold <= w_rd_data;
    end
  end

  assign do_preamble_vld = r_pre_vld;
  assign do_sigpld_vld   = r_sig_vld;
  assign do_preamble_re  = r_pre_vld ? w_rd_data[2*DW-1:DW] : r_pre_hold[2*DW-1:DW];
  assign do_preamble_im  = r_pre_vld ? w_rd_data[DW-1:0]    : r_pre_hold[DW-1:0];
  assign do_sigpld_re    = r_sig_vld ? w_rd_data[2*DW-1:DW] : r_sig_hold[2*DW-1:DW];
  assign do_sigpld_im    = r_sig_vld ? w_rd_data[DW-1:0]    : r_sig_hold[DW-1:0];

endmodule

`default_nettype wire

// File: tb/tb_dsep.sv
//------------------------------------------------------------------------------
// tb_dsep : randomized self-checking bench for dsep against a sample-count model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dsep;
  import dsep_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] di_re, di_im;
  logic          di_vld;
  logic [AW-1:0] max_indx;
  logic          max_indx_vld;
  logic [DW-1:0] do_preamble_re, do_preamble_im, do_sigpld_re, do_sigpld_im;
  logic          do_preamble_vld, do_sigpld_vld;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain circular array, pointers as integers, and a single
  // count of samples consumed since the last restart decides the output port.
  logic [2*DW-1:0] m_mem [DEPTH];
  int              m_wr, m_rd, m_n;
  bit              m_act;
  logic            m_pre_vld, m_sig_vld;
  logic [2*DW-1:0] m_pre_d, m_sig_d;

  bit chk_first_lts = 1'b0;
  bit chk_first_sig = 1'b0;

  always #5 clk = ~clk;

  dsep dut (
    .clk             (clk),
    .rst             (rst),
    .di_re           (di_re),
    .di_im           (di_im),
    .di_vld          (di_vld),
    .max_indx        (max_indx),
    .max_indx_vld    (max_indx_vld),
    .do_preamble_re  (do_preamble_re),
    .do_preamble_im  (do_preamble_im),
    .do_preamble_vld (do_preamble_vld),
    .do_sigpld_re    (do_sigpld_re),
    .do_sigpld_im    (do_sigpld_im),
    .do_sigpld_vld   (do_sigpld_vld)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_n = 0; m_act = 1'b0;
    m_pre_vld = 1'b0; m_sig_vld = 1'b0;
    m_pre_d = '0; m_sig_d = '0;
  endtask

  task automatic model_edge(input logic vld, input logic [2*DW-1:0] d,
                            input logic pulse, input int idx);
    int k;
    m_pre_vld = 1'b0;
    m_sig_vld = 1'b0;
    if (pulse) begin
      m_rd = idx; m_n = 0; m_act = 1'b1;
    end else if (m_act && m_rd != m_wr) begin
      if (m_n < N_LTS) begin
        m_pre_vld = 1'b1; m_pre_d = m_mem[m_rd];
      end else begin
        k = (m_n - N_LTS) % SYM_LEN;
        if (k >= N_CP) begin
          m_sig_vld = 1'b1; m_sig_d = m_mem[m_rd];
        end
      end
      m_n++;
      m_rd = (m_rd + 1) % DEPTH;
    end
    if (vld) begin
      m_mem[m_wr] = d;
      m_wr = (m_wr + 1) % DEPTH;
    end
  endtask

  task automatic check_all();
    chk("pre_vld", 32'(do_preamble_vld), 32'(m_pre_vld));
    chk("sig_vld", 32'(do_sigpld_vld), 32'(m_sig_vld));
    chk("pre_re",  32'(do_preamble_re), 32'(m_pre_d[2*DW-1:DW]));
    chk("pre_im",  32'(do_preamble_im), 32'(m_pre_d[DW-1:0]));
    chk("sig_re",  32'(do_sigpld_re), 32'(m_sig_d[2*DW-1:DW]));
    chk("sig_im",  32'(do_sigpld_im), 32'(m_sig_d[DW-1:0]));
    chk("strobe_excl", 32'(do_preamble_vld & do_sigpld_vld), 32'd0);
    if (chk_first_lts && do_preamble_vld) begin
      chk("first_lts", 32'(do_preamble_re), 32'd1131);
      chk_first_lts = 1'b0;
    end
    if (chk_first_sig && do_sigpld_vld) begin
      chk("first_sig", 32'(do_sigpld_re), 32'd1275);
      chk_first_sig = 1'b0;
    end
  endtask

  // One clock: apply inputs, advance model at the edge, compare at the falling edge
  task automatic step(input logic vld, input logic [2*DW-1:0] d,
                      input logic pulse, input int idx);
    di_vld       = vld;
    di_re        = d[2*DW-1:DW];
    di_im        = d[DW-1:0];
    max_indx_vld = pulse;
    max_indx     = AW'(idx);
    @(posedge clk);
    if (rst) model_edge(vld, d, pulse, idx);
    else     model_reset();
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [2*DW-1:0] rnd_sample();
    return 24'($urandom);
  endfunction

  initial begin
    logic [DW-1:0] kk;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    rst = 1'b0; di_vld = 1'b0; di_re = '0; di_im = '0;
    max_indx = '0; max_indx_vld = 1'b0;
    model_reset();

    // Held in reset with input strobing: outputs must stay quiet
    for (int i = 0; i < 10; i++) step(1'(i % 2), rnd_sample(), 1'b0, 0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 0);

    // Ramp, one sample every third cycle, with two restarts
    for (int k = 0; k < 3500; k++) begin
      kk = DW'(k);
      step(1'b1, {kk, kk}, 1'b0, 0);
      if (k == 1701) begin
        chk_first_lts = 1'b1;
        chk_first_sig = 1'b1;
        step(1'b0, '0, 1'b1, 107);
      end else if (k == 2800) begin
        step(1'b0, '0, 1'b1, 300);
      end else begin
        step(1'b0, '0, 1'b0, 0);
      end
      step(1'b0, '0, 1'b0, 0);
    end

    // Restart just behind the write pointer, random input spacing
    step(1'b0, '0, 1'b1, (m_wr - 5 + DEPTH) % DEPTH);
    for (int i = 0; i < 900; i++)
      step(1'($urandom_range(0, 2) == 0), rnd_sample(), 1'b0, 0);

    // Reset in the middle of a preamble
    step(1'b0, '0, 1'b1, (m_wr - 200 + DEPTH) % DEPTH);
    for (int i = 0; i < 50; i++) step(1'($urandom_range(0, 1)), rnd_sample(), 1'b0, 0);
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    for (int i = 0; i < 5; i++) step(1'(i % 2), rnd_sample(), 1'b0, 0);
    rst = 1'b1;
    for (int i = 0; i < 150; i++) step(1'b1, rnd_sample(), 1'b0, 0);
    step(1'b0, '0, 1'b1, (m_wr - 100 + DEPTH) % DEPTH);
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), rnd_sample(), 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
